enter_debounce: RTL and testbench
=================================

# enter_debounce

Input conditioner that sits directly upstream of the guessing-game top. It turns the raw, bouncing enter push-button into a single-cycle, debounced `enter` pulse. It also presents a synchronized guess value that is captured at the moment of the pulse, so the game control and datapath see one clean event per physical press and a guess that is stable for the whole check.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
- `GUESS_W`, default 8: width of the guess bus.

Ports:
- `clk` input, 1: single system clock, rising-edge.
- `reset` input, 1: asynchronous, active-low reset (asserted when 0).
- `i_button` input, 1: raw enter button, active-high, asynchronous to `clk`.
- `i_guess` input, `GUESS_W`: raw slide switches, asynchronous.
- `o_enter` output, 1: one-cycle pulse per accepted press; drives the game's `enter`.
- `o_guess` output, `GUESS_W`: guess captured on the accepted press; drives the game's `guess`.
- `o_held` output, 1: high while the debounced button is in the pressed state.
- `o_presses` output, 8: accepted-press count (see Configuration).

## Operation
- `i_button` and each `i_guess` bit each pass through a 2-flop synchronizer. The synchronized button is `s`; the synchronized guess is `g`.
- FSM states:
  - S_IDLE: debounced released. `s`=1 → S_PRESS_WAIT with `cnt`=1.
  - S_PRESS_WAIT: `s`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → S_HELD, and register `o_enter`=1 and `o_guess`=`g` at the same edge. `s`=1 otherwise → `cnt`+1. `s`=0 → S_IDLE with `cnt`=0; no pulse.
  - S_HELD: `s`=0 → S_RELEASE_WAIT with `cnt`=1.
  - S_RELEASE_WAIT: `s`=0 and `cnt`==`DEBOUNCE_CYCLES`-1 → S_IDLE. `s`=0 otherwise → `cnt`+1. `s`=1 → S_HELD with `cnt`=0.
- Releases never pulse. Exactly one `o_enter` per accepted press, regardless of hold length.
- `o_held` is 1 in S_HELD and S_RELEASE_WAIT.
- `o_guess` changes only on the `o_enter` edge. It holds its value between presses, including while the switches move.
- `cnt` width is `$clog2(DEBOUNCE_CYCLES)`. `cnt` never exceeds `DEBOUNCE_CYCLES`-1 and never wraps.
- Reset (`reset`=0, any time, including mid-debounce or mid-hold):
  - state → S_IDLE, `cnt`=0, synchronizer flops=0;
  - `o_enter`=0, `o_guess`=0, `o_held`=0, `o_presses`=0.
- A button held through reset deassertion is treated as a new press: one pulse after the full debounce.

## Timing
- Take edge 0 as the first rising edge at which `i_button`=1 meets setup, with the button held clean.
  - `s`=1 after edge 1.
  - The first S_IDLE sample of `s` is at edge 2.
  - `o_enter` is high from edge `DEBOUNCE_CYCLES`+1 to edge `DEBOUNCE_CYCLES`+2.
- `o_guess` updates at the same edge `o_enter` rises. It reflects `g` as sampled at that edge, which is the switch value from 2 edges earlier.
- `o_held` rises with `o_enter`.
- `o_held` falls `DEBOUNCE_CYCLES`+1 edges after the first clean edge with `i_button`=0.
- Minimum spacing between two `o_enter` pulses: 2·`DEBOUNCE_CYCLES` cycles.

## Configuration
- `ENTER_PRESS_COUNT_EN`:
  - Defined: an 8-bit counter increments on every `o_enter` and saturates at 255 (no wrap). It is cleared only by reset and drives `o_presses`.
  - Undefined: no counter logic; `o_presses` is tied to 0. All other behaviour is identical.

## Structure
- Package `enter_pkg` holds:
  - the state enum typedef (S_IDLE, S_PRESS_WAIT, S_HELD, S_RELEASE_WAIT);
  - `DEFAULT_DEBOUNCE_CYCLES`=16;
  - `PRESS_CNT_W`=8.
- Sub-module `sync2`: a parameterized-width 2-flop synchronizer with async active-low reset to 0. It is instanced once for `i_button` (width 1) and once for `i_guess` (width `GUESS_W`).

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset then clean press of 20 cycles with `i_guess`=8'h2A → `o_enter`=1 for exactly the cycle between edges 5 and 6; `o_guess`=8'h2A; `o_held` rises with `o_enter`; no pulse on release.
- Press bouncing 1,0,1,1,0 (one sample per cycle), then steady 1 → no pulse during the bounce; a single pulse 4 stable samples after the last 0.
- Hold for 100 cycles while `i_guess` changes 8'h10→8'h55 after the pulse → exactly one pulse; `o_guess` stays 8'h10.
- Release glitch: a 2-cycle 0 inside S_HELD → state returns to S_HELD; no new pulse on re-press; `o_held` stays 1.
- Assert reset in S_PRESS_WAIT and in S_HELD while the button stays pressed → all outputs 0 immediately; after deassertion, one pulse 5 edges later.
- With `ENTER_PRESS_COUNT_EN` defined: 300 clean presses → `o_presses` reaches 255 and stays there. Without the macro: `o_presses`=0 throughout.

Source files
------------

// File: rtl/enter_pkg.sv
// Shared types and constants for the enter-button conditioner.
package enter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int PRESS_CNT_W             = 8;

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer; both stages reset to 0.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/enter_debounce.sv
// Debounces the enter button into a one-cycle pulse and captures the guess on it.
// Optional saturating press counter enabled by ENTER_PRESS_COUNT_EN.
module enter_debounce
  import enter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int GUESS_W         = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_button,
  input  logic [GUESS_W-1:0]     i_guess,
  output logic                   o_enter,
  output logic [GUESS_W-1:0]     o_guess,
  output logic                   o_held,
  output logic [PRESS_CNT_W-1:0] o_presses
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               s;
  logic [GUESS_W-1:0] g;

  sync2 #(.W(1)) u_sync_button (
    .clk   (clk),
    .reset (reset),
    .d     (i_button),
    .q     (s)
  );

  sync2 #(.W(GUESS_W)) u_sync_guess (
    .clk   (clk),
    .reset (reset),
    .d     (i_guess),
    .q     (g)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               enter_q, enter_d;
  logic [GUESS_W-1:0] guess_q, guess_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter_d = 1'b0;
    guess_d = guess_q;
    case (state_q)
      S_IDLE: begin
        if (s) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      S_PRESS_WAIT: begin
        if (!s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Pulse and guess capture share the edge that accepts the press.
          state_d = S_HELD;
          cnt_d   = '0;
          enter_d = 1'b1;
          guess_d = g;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HELD: begin
        if (!s) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      S_RELEASE_WAIT: begin
        if (s) begin
          state_d = S_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      enter_q <= 1'b0;
      guess_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enter_q <= enter_d;
      guess_q <= guess_d;
    end
  end

  assign o_enter = enter_q;
  assign o_guess = guess_q;
  assign o_held  = (state_q == S_HELD) || (state_q == S_RELEASE_WAIT);

`ifdef ENTER_PRESS_COUNT_EN
  logic [PRESS_CNT_W-1:0] presses_q, presses_d;

  // Counts alongside the pulse edge and sticks at all-ones.
  always_comb begin
    presses_d = presses_q;
    if (enter_d && (presses_q != {PRESS_CNT_W{1'b1}})) begin
      presses_d = presses_q + PRESS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presses_q <= '0;
    end else begin
      presses_q <= presses_d;
    end
  end

  assign o_presses = presses_q;
`else
  assign o_presses = '0;
`endif

endmodule

// File: tb/tb_enter_debounce.sv
// Self-checking bench for enter_debounce with DEBOUNCE_CYCLES=4, directed and random stimulus.
module tb_enter_debounce;

  localparam int D  = 4;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_button = 1'b0;
  logic [GW-1:0] i_guess = '0;
  logic          o_enter;
  logic          o_held;
  logic [GW-1:0] o_guess;
  logic [7:0]    o_presses;

  int errors = 0;
  int checks = 0;

  // Reference model: sync pipeline plus "D consecutive disagreeing samples flip the level"
  bit          m_sb1, m_sb2;
  logic [GW-1:0] m_sg1, m_sg2;
  bit          m_deb;
  bit          m_enter;
  int          m_run;
  logic [GW-1:0] m_guess;
  int          m_presses;

  int edge_no = 0;
  int pulses = 0;
  int last_pulse_edge = -1;

  always #5 clk = ~clk;

  enter_debounce #(.DEBOUNCE_CYCLES(D), .GUESS_W(GW)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_button  (i_button),
    .i_guess   (i_guess),
    .o_enter   (o_enter),
    .o_guess   (o_guess),
    .o_held    (o_held),
    .o_presses (o_presses)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    m_sb1 = 0; m_sb2 = 0; m_sg1 = '0; m_sg2 = '0;
    m_deb = 0; m_enter = 0; m_run = 0; m_guess = '0; m_presses = 0;
  endtask

  task automatic model_edge(input bit b, input logic [GW-1:0] gsw);
    bit s;
    logic [GW-1:0] gs;
    s  = m_sb2;
    gs = m_sg2;
    m_enter = 0;
    if (s != m_deb) m_run++;
    else m_run = 0;
    if (m_run == D) begin
      m_deb = s;
      m_run = 0;
      if (s) begin
        m_enter = 1;
        m_guess = gs;
        if (m_presses < 255) m_presses++;
      end
    end
    m_sb2 = m_sb1; m_sb1 = b;
    m_sg2 = m_sg1; m_sg1 = gsw;
  endtask

  function automatic int exp_presses();
`ifdef ENTER_PRESS_COUNT_EN
    return m_presses;
`else
    return 0;
`endif
  endfunction

  task automatic compare_all(input string where);
    check({where, ".enter"},   32'(o_enter),   32'(m_enter));
    check({where, ".held"},    32'(o_held),    32'(m_deb));
    check({where, ".guess"},   32'(o_guess),   32'(m_guess));
    check({where, ".presses"}, 32'(o_presses), 32'(exp_presses()));
  endtask

  // One clock: drive on the falling edge, update the model on the rising edge, compare 1ns later.
  task automatic step(input bit b, input logic [GW-1:0] gsw, input string where);
    @(negedge clk);
    i_button = b;
    i_guess  = gsw;
    @(posedge clk);
    if (reset) model_edge(b, gsw);
    edge_no++;
    #1;
    if (o_enter === 1'b1) begin
      pulses++;
      last_pulse_edge = edge_no;
    end
    compare_all(where);
  endtask

  task automatic async_reset_check(input string where);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check({where, ".rst_enter"},   32'(o_enter),   32'd0);
    check({where, ".rst_held"},    32'(o_held),    32'd0);
    check({where, ".rst_guess"},   32'(o_guess),   32'd0);
    check({where, ".rst_presses"}, 32'(o_presses), 32'd0);
  endtask

  initial begin
    int e0;
    int p0;
    int last0;
    bit lvl;
    model_reset();

    // Reset state
    @(posedge clk); #1;
    compare_all("reset");
    step(1'b0, 8'h00, "reset_hold");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step(1'b0, 8'h2A, "idle");

    // Clean 20-cycle press with guess 2A; pulse expected D+1 edges after edge 0
    p0 = pulses;
    e0 = edge_no + 1;
    repeat (20) step(1'b1, 8'h2A, "clean_press");
    check("clean.pulse_count", 32'(pulses - p0), 32'd1);
    check("clean.pulse_edge",  32'(last_pulse_edge - e0), 32'(D + 1));
    check("clean.guess",       32'(o_guess), 32'h2A);
    repeat (12) step(1'b0, 8'h2A, "clean_release");
    check("clean.release_no_pulse", 32'(pulses - p0), 32'd1);
    check("clean.released", 32'(o_held), 32'd0);

    // Bounce 1,0,1,1,0 then steady 1
    p0 = pulses;
    step(1'b1, 8'h33, "bounce");
    step(1'b0, 8'h33, "bounce");
    step(1'b1, 8'h33, "bounce");
    step(1'b1, 8'h33, "bounce");
    step(1'b0, 8'h33, "bounce");
    last0 = edge_no;
    repeat (15) step(1'b1, 8'h33, "bounce_steady");
    check("bounce.pulse_count", 32'(pulses - p0), 32'd1);
    check("bounce.pulse_edge",  32'(last_pulse_edge - last0), 32'(D + 2));
    repeat (12) step(1'b0, 8'h33, "bounce_release");

    // Long hold while the switches change after the pulse
    p0 = pulses;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, (pulses > p0) ? 8'h55 : 8'h10, "long_hold");
    end
    check("hold.pulse_count", 32'(pulses - p0), 32'd1);
    check("hold.guess",       32'(o_guess), 32'h10);
    repeat (12) step(1'b0, 8'h55, "hold_release");

    // Two-cycle release glitch while held
    p0 = pulses;
    repeat (12) step(1'b1, 8'h66, "glitch_press");
    repeat (2)  step(1'b0, 8'h66, "glitch_low");
    repeat (10) step(1'b1, 8'h66, "glitch_repress");
    check("glitch.pulse_count", 32'(pulses - p0), 32'd1);
    check("glitch.held",        32'(o_held), 32'd1);
    repeat (12) step(1'b0, 8'h66, "glitch_release");

    // Reset during press-wait with button held, then during held
    repeat (3) step(1'b1, 8'h77, "pw_press");
    async_reset_check("rst_pw");
    repeat (2) step(1'b1, 8'h77, "pw_in_reset");
    reset = 1'b1;
    p0 = pulses;
    e0 = edge_no + 1;
    repeat (10) step(1'b1, 8'h77, "pw_after");
    check("rst_pw.pulse_count", 32'(pulses - p0), 32'd1);
    check("rst_pw.pulse_edge",  32'(last_pulse_edge - e0), 32'(D + 1));
    async_reset_check("rst_held");
    repeat (2) step(1'b1, 8'h78, "held_in_reset");
    reset = 1'b1;
    p0 = pulses;
    e0 = edge_no + 1;
    repeat (10) step(1'b1, 8'h78, "held_after");
    check("rst_held.pulse_count", 32'(pulses - p0), 32'd1);
    check("rst_held.pulse_edge",  32'(last_pulse_edge - e0), 32'(D + 1));
    check("rst_held.guess",       32'(o_guess), 32'h78);
    repeat (12) step(1'b0, 8'h78, "held_release");

    // Random bouncy stimulus with a mid-run reset
    lvl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 15) lvl = ~lvl;
      if (i == 300) begin
        async_reset_check("rand_rst");
        step(lvl, 8'($urandom), "rand_in_reset");
        reset = 1'b1;
      end
      step(lvl, 8'($urandom), "random");
    end
    repeat (12) step(1'b0, 8'h00, "random_release");

    // 300 clean presses: counter saturates at 255 (or stays 0 when disabled)
    async_reset_check("sat_rst");
    step(1'b0, 8'h00, "sat_in_reset");
    reset = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 300; i++) begin
      repeat (D + 2) step(1'b1, 8'(i), "sat_press");
      repeat (D + 2) step(1'b0, 8'(i), "sat_release");
    end
    check("sat.pulse_count", 32'(pulses - p0), 32'd300);
`ifdef ENTER_PRESS_COUNT_EN
    check("sat.presses", 32'(o_presses), 32'd255);
`else
    check("sat.presses", 32'(o_presses), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
